// File: rtl/branch_resolve_unit_if.sv
// EX-side branch operands and MEM-side resolution results.
// The master drives the EX inputs and the slave (the resolve unit) drives the results.
interface branch_resolve_unit_if #(
  parameter int GHR_LENGTH = 8,
  parameter int CNT_W      = 32
);
  logic                  stallE;
  logic                  flushM;
  logic                  branchE;
  logic [2:0]            branch_opE;
  logic [31:0]           src_aE;
  logic [31:0]           src_bE;
  logic [31:0]           pcE;
  logic [15:0]           offsetE;
  logic                  pred_takeE;
  logic [GHR_LENGTH-1:0] ghr_snapE;
  logic                  cnt_clr;
  logic                  actual_takeE;
  logic                  branchM;
  logic                  actual_takeM;
  logic                  pred_wrongM;
  logic [31:0]           redirect_pcM;
  logic [GHR_LENGTH-1:0] ghr_fixM;
  logic [CNT_W-1:0]      branch_cnt;
  logic [CNT_W-1:0]      mispred_cnt;

  modport master (
    output stallE, flushM, branchE, branch_opE, src_aE, src_bE, pcE, offsetE,
           pred_takeE, ghr_snapE, cnt_clr,
    input  actual_takeE, branchM, actual_takeM, pred_wrongM, redirect_pcM,
           ghr_fixM, branch_cnt, mispred_cnt
  );

  modport slave (
    input  stallE, flushM, branchE, branch_opE, src_aE, src_bE, pcE, offsetE,
           pred_takeE, ghr_snapE, cnt_clr,
    output actual_takeE, branchM, actual_takeM, pred_wrongM, redirect_pcM,
           ghr_fixM, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: computes the direction and target in EX, registers the
// outcome and mispredict flag into MEM, and keeps saturating branch statistics.
module branch_resolve_unit #(
  parameter int GHR_LENGTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);

  logic                  dirTake;
  logic                  takeE;
  logic                  validE;
  logic [31:0]           seqPc;
  logic [31:0]           targetPc;
  logic [31:0]           offsetBytes;

  logic                  branchMq;
  logic                  takeMq;
  logic                  wrongMq;
  logic [31:0]           redirectMq;
  logic [GHR_LENGTH-1:0] ghrFixMq;
  logic [CNT_W-1:0]      branchCnt;
  logic [CNT_W-1:0]      mispredCnt;

  // Direction from the op code; the zero compares are signed so they reduce to sign-bit tests.
  always_comb begin
    dirTake = 1'b0;
    case (bus.branch_opE)
      3'b000:  dirTake = (bus.src_aE == bus.src_bE);
      3'b001:  dirTake = (bus.src_aE != bus.src_bE);
      3'b010:  dirTake = ~bus.src_aE[31];
      3'b011:  dirTake = ~bus.src_aE[31] & (bus.src_aE != 32'd0);
      3'b100:  dirTake = bus.src_aE[31] | (bus.src_aE == 32'd0);
      3'b101:  dirTake = bus.src_aE[31];
      default: dirTake = 1'b0;
    endcase
  end

  // Gated by rst so the combinational output also reads 0 while the unit is in reset.
  assign takeE  = rst & bus.branchE & dirTake;
  // A branch behind a mispredict in MEM is on the wrong path, even if its flush is late.
  assign validE = bus.branchE & ~wrongMq;

  assign offsetBytes = {{14{bus.offsetE[15]}}, bus.offsetE, 2'b00};
  assign seqPc       = bus.pcE + 32'd4;
  assign targetPc    = takeE ? (seqPc + offsetBytes) : seqPc;

  // EX->MEM register; a bubble clears the valid/mispredict bits but keeps the payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchMq   <= 1'b0;
      takeMq     <= 1'b0;
      wrongMq    <= 1'b0;
      redirectMq <= 32'd0;
      ghrFixMq   <= '0;
    end else if (bus.flushM || bus.stallE) begin
      branchMq <= 1'b0;
      wrongMq  <= 1'b0;
    end else begin
      branchMq   <= validE;
      takeMq     <= takeE;
      wrongMq    <= validE & (bus.pred_takeE != takeE);
      redirectMq <= targetPc;
      ghrFixMq   <= {bus.ghr_snapE[GHR_LENGTH-2:0], takeE};
    end
  end

  // Statistics counters: clear wins over increment, both stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else if (bus.cnt_clr) begin
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else begin
      if (branchMq && (branchCnt != '1))  branchCnt  <= branchCnt + CNT_W'(1);
      if (wrongMq && (mispredCnt != '1))  mispredCnt <= mispredCnt + CNT_W'(1);
    end
  end

  assign bus.actual_takeE = takeE;
  assign bus.branchM      = branchMq;
  assign bus.actual_takeM = takeMq;
  assign bus.pred_wrongM  = wrongMq;
  assign bus.redirect_pcM = redirectMq;
  assign bus.ghr_fixM     = ghrFixMq;
  assign bus.branch_cnt   = branchCnt;
  assign bus.mispred_cnt  = mispredCnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run against a cycle-level reference model. A second instance
// with 3-bit counters shares the stimulus so saturation is reachable quickly.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  branch_resolve_unit_if #(.GHR_LENGTH(8), .CNT_W(32)) bus ();
  branch_resolve_unit_if #(.GHR_LENGTH(8), .CNT_W(3))  bus3 ();

  branch_resolve_unit #(.GHR_LENGTH(8), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  branch_resolve_unit #(.GHR_LENGTH(8), .CNT_W(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign bus3.stallE     = bus.stallE;
  assign bus3.flushM     = bus.flushM;
  assign bus3.branchE    = bus.branchE;
  assign bus3.branch_opE = bus.branch_opE;
  assign bus3.src_aE     = bus.src_aE;
  assign bus3.src_bE     = bus.src_bE;
  assign bus3.pcE        = bus.pcE;
  assign bus3.offsetE    = bus.offsetE;
  assign bus3.pred_takeE = bus.pred_takeE;
  assign bus3.ghr_snapE  = bus.ghr_snapE;
  assign bus3.cnt_clr    = bus.cnt_clr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state (what MEM and the counters should show)
  logic        mBr, mTk, mWr;
  logic [31:0] mPc;
  logic [7:0]  mGhr;
  longint      mB, mM, mB3, mM3;
  localparam longint MAX32 = 64'hFFFF_FFFF;

  function automatic logic dirRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) >= 0;
      3'd3:    return $signed(a) > 0;
      3'd4:    return $signed(a) <= 0;
      3'd5:    return $signed(a) < 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    mBr = 0; mTk = 0; mWr = 0; mPc = 0; mGhr = 0;
    mB = 0; mM = 0; mB3 = 0; mM3 = 0;
  endtask

  task automatic drive(input logic br, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [15:0] off,
                       input logic pred, input logic [7:0] snap);
    bus.branchE = br; bus.branch_opE = op; bus.src_aE = a; bus.src_bE = b;
    bus.pcE = pc; bus.offsetE = off; bus.pred_takeE = pred; bus.ghr_snapE = snap;
  endtask

  // advance one clock, updating the model from the inputs presented before the edge
  task automatic step();
    logic tk, vld;
    tk = bus.branchE && dirRef(bus.branch_opE, bus.src_aE, bus.src_bE);
    if (bus.cnt_clr) begin
      mB = 0; mM = 0; mB3 = 0; mM3 = 0;
    end else begin
      if (mBr) begin if (mB < MAX32) mB++; if (mB3 < 7) mB3++; end
      if (mWr) begin if (mM < MAX32) mM++; if (mM3 < 7) mM3++; end
    end
    vld = bus.branchE && !mWr;
    if (bus.flushM || bus.stallE) begin
      mBr = 0; mWr = 0;
    end else begin
      mBr  = vld;
      mTk  = tk;
      mWr  = vld && (bus.pred_takeE != tk);
      mPc  = tk ? bus.pcE + 32'd4 + 32'(int'($signed(bus.offsetE)) * 4) : bus.pcE + 32'd4;
      mGhr = {bus.ghr_snapE[6:0], tk};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.stallE = 0; bus.flushM = 0; bus.cnt_clr = 0;
    drive(1, 3'd0, 32'd7, 32'd7, 32'h100, 16'h1, 1'b0, 8'hFF);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.branchM !== 1'b0) begin fails++; $display("FAIL reset_branchM got=%b want=0", bus.branchM); end
    tests++; if (bus.pred_wrongM !== 1'b0) begin fails++; $display("FAIL reset_pred_wrongM got=%b want=0", bus.pred_wrongM); end
    tests++; if (bus.redirect_pcM !== 32'd0) begin fails++; $display("FAIL reset_redirect got=%h want=0", bus.redirect_pcM); end
    tests++; if (bus.ghr_fixM !== 8'd0) begin fails++; $display("FAIL reset_ghr got=%h want=0", bus.ghr_fixM); end
    tests++; if (bus.actual_takeE !== 1'b0) begin fails++; $display("FAIL reset_actual_takeE got=%b want=0", bus.actual_takeE); end
    tests++; if (bus.branch_cnt !== 32'd0 || bus.mispred_cnt !== 32'd0) begin
      fails++; $display("FAIL reset_counters got=%h/%h want=0/0", bus.branch_cnt, bus.mispred_cnt); end
    #2 rst = 1'b1;
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_beq_mispredict();
    drive(1, 3'd0, 32'd5, 32'd5, 32'h0040_0010, 16'h0003, 1'b0, 8'h00);
    #1;
    tests++; if (bus.actual_takeE !== 1'b1) begin fails++; $display("FAIL beq_actual_takeE got=%b want=1", bus.actual_takeE); end
    step();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    tests++; if (bus.branchM !== 1'b1) begin fails++; $display("FAIL beq_branchM got=%b want=1", bus.branchM); end
    tests++; if (bus.actual_takeM !== 1'b1) begin fails++; $display("FAIL beq_actual_takeM got=%b want=1", bus.actual_takeM); end
    tests++; if (bus.pred_wrongM !== 1'b1) begin fails++; $display("FAIL beq_pred_wrongM got=%b want=1", bus.pred_wrongM); end
    tests++; if (bus.redirect_pcM !== 32'h0040_0020) begin fails++; $display("FAIL beq_redirect got=%h want=00400020", bus.redirect_pcM); end
    step();
    tests++; if (bus.pred_wrongM !== 1'b0) begin fails++; $display("FAIL beq_wrong_one_cycle got=%b want=0", bus.pred_wrongM); end
  endtask

  task automatic test_bltz_correct();
    bus.cnt_clr = 1; step(); bus.cnt_clr = 0;
    drive(1, 3'd5, 32'hFFFF_FFFF, 32'd0, 32'h0040_0100, 16'hFFFE, 1'b1, 8'h00);
    step();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    tests++; if (bus.pred_wrongM !== 1'b0) begin fails++; $display("FAIL bltz_pred_wrongM got=%b want=0", bus.pred_wrongM); end
    tests++; if (bus.redirect_pcM !== 32'h0040_00FC) begin fails++; $display("FAIL bltz_redirect got=%h want=004000fc", bus.redirect_pcM); end
    step();
    tests++; if (bus.branch_cnt !== 32'd1) begin fails++; $display("FAIL bltz_branch_cnt got=%0d want=1", bus.branch_cnt); end
    tests++; if (bus.mispred_cnt !== 32'd0) begin fails++; $display("FAIL bltz_mispred_cnt got=%0d want=0", bus.mispred_cnt); end
  endtask

  task automatic test_back_to_back();
    bus.cnt_clr = 1; step(); bus.cnt_clr = 0;
    drive(1, 3'd1, 32'd1, 32'd2, 32'h0000_1000, 16'h0010, 1'b0, 8'h00);
    step();
    drive(1, 3'd0, 32'd3, 32'd3, 32'h0000_1004, 16'h0020, 1'b0, 8'h00);
    tests++; if (bus.pred_wrongM !== 1'b1) begin fails++; $display("FAIL b2b_first_wrong got=%b want=1", bus.pred_wrongM); end
    step();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    tests++; if (bus.branchM !== 1'b0) begin fails++; $display("FAIL b2b_second_branchM got=%b want=0", bus.branchM); end
    tests++; if (bus.pred_wrongM !== 1'b0) begin fails++; $display("FAIL b2b_second_wrong got=%b want=0", bus.pred_wrongM); end
    step();
    tests++; if (bus.branch_cnt !== 32'd1 || bus.mispred_cnt !== 32'd1) begin
      fails++; $display("FAIL b2b_counters got=%0d/%0d want=1/1", bus.branch_cnt, bus.mispred_cnt); end
  endtask

  task automatic test_ghr();
    drive(1, 3'd3, 32'd9, 32'd0, 32'h0000_2000, 16'h0001, 1'b1, 8'b1011_0010);
    step();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    tests++; if (bus.ghr_fixM !== 8'b0110_0101) begin fails++; $display("FAIL ghr_fix got=%b want=01100101", bus.ghr_fixM); end
    step();
  endtask

  task automatic test_saturate();
    // ten separated mispredicts push the 3-bit counters past their top
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'd4, 32'd0, 32'd0, 32'h3000 + 32'(i * 8), 16'h0004, 1'b0, 8'h00);
      step();
      drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
      step();
    end
    tests++; if (bus3.mispred_cnt !== 3'd7) begin fails++; $display("FAIL sat_mispred got=%0d want=7", bus3.mispred_cnt); end
    tests++; if (bus3.branch_cnt !== 3'd7) begin fails++; $display("FAIL sat_branch got=%0d want=7", bus3.branch_cnt); end
    tests++; if (bus.mispred_cnt !== mM[31:0]) begin fails++; $display("FAIL sat_wide_mispred got=%0d want=%0d", bus.mispred_cnt, mM[31:0]); end
    drive(1, 3'd0, 32'd1, 32'd1, 32'h4000, 16'h0002, 1'b1, 8'h00);
    step();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    tests++; if (bus.branchM !== 1'b1) begin fails++; $display("FAIL clr_setup_branchM got=%b want=1", bus.branchM); end
    bus.cnt_clr = 1;
    step();
    bus.cnt_clr = 0;
    tests++; if (bus.branch_cnt !== 32'd0 || bus.mispred_cnt !== 32'd0) begin
      fails++; $display("FAIL clr_wide got=%0d/%0d want=0/0", bus.branch_cnt, bus.mispred_cnt); end
    tests++; if (bus3.branch_cnt !== 3'd0 || bus3.mispred_cnt !== 3'd0) begin
      fails++; $display("FAIL clr_narrow got=%0d/%0d want=0/0", bus3.branch_cnt, bus3.mispred_cnt); end
  endtask

  task automatic test_async_reset();
    drive(1, 3'd2, 32'd4, 32'd0, 32'h5000, 16'h0008, 1'b0, 8'hA5);
    step();
    tests++; if (bus.pred_wrongM !== 1'b1) begin fails++; $display("FAIL areset_setup got=%b want=1", bus.pred_wrongM); end
    #2 rst = 1'b0;
    #1;
    tests++; if ({bus.branchM, bus.actual_takeM, bus.pred_wrongM, bus.actual_takeE} !== 4'b0) begin
      fails++; $display("FAIL areset_flags got=%b want=0000", {bus.branchM, bus.actual_takeM, bus.pred_wrongM, bus.actual_takeE}); end
    tests++; if (bus.redirect_pcM !== 32'd0 || bus.ghr_fixM !== 8'd0) begin
      fails++; $display("FAIL areset_data got=%h/%h want=0/0", bus.redirect_pcM, bus.ghr_fixM); end
    tests++; if (bus.branch_cnt !== 32'd0 || bus.mispred_cnt !== 32'd0) begin
      fails++; $display("FAIL areset_counters got=%0d/%0d want=0/0", bus.branch_cnt, bus.mispred_cnt); end
    #1 rst = 1'b1;
    modelReset();
    bus.stallE = 1;
    step();
    tests++; if (bus.branchM !== 1'b0) begin fails++; $display("FAIL stall_branchM got=%b want=0", bus.branchM); end
    bus.stallE = 0; bus.flushM = 1;
    step();
    tests++; if (bus.branchM !== 1'b0 || bus.pred_wrongM !== 1'b0) begin
      fails++; $display("FAIL flush_branchM got=%b/%b want=0/0", bus.branchM, bus.pred_wrongM); end
    bus.flushM = 0;
    step();
    tests++; if (bus.branchM !== 1'b1 || bus.pred_wrongM !== 1'b1) begin
      fails++; $display("FAIL after_stall_branch got=%b/%b want=1/1", bus.branchM, bus.pred_wrongM); end
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        expTk;
    for (int i = 0; i < 400; i++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0: a = 32'd0;
        1: a = 32'($urandom_range(0, 3)) - 32'd1;
        default: ;
      endcase
      b = ($urandom_range(0, 2) == 0) ? a : $urandom();
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom()), a, b, $urandom(),
            16'($urandom()), 1'($urandom()), 8'($urandom()));
      bus.stallE  = ($urandom_range(0, 9) == 0);
      bus.flushM  = ($urandom_range(0, 9) == 0);
      bus.cnt_clr = ($urandom_range(0, 49) == 0);
      #1;
      expTk = bus.branchE && dirRef(bus.branch_opE, bus.src_aE, bus.src_bE);
      tests++; if (bus.actual_takeE !== expTk) begin fails++; $display("FAIL rnd_actual_takeE i=%0d got=%b want=%b", i, bus.actual_takeE, expTk); end
      step();
      tests++; if ({bus.branchM, bus.pred_wrongM} !== {mBr, mWr}) begin
        fails++; $display("FAIL rnd_flags i=%0d got=%b%b want=%b%b", i, bus.branchM, bus.pred_wrongM, mBr, mWr); end
      tests++; if (bus.actual_takeM !== mTk || bus.redirect_pcM !== mPc || bus.ghr_fixM !== mGhr) begin
        fails++; $display("FAIL rnd_payload i=%0d got=%b/%h/%h want=%b/%h/%h", i, bus.actual_takeM, bus.redirect_pcM, bus.ghr_fixM, mTk, mPc, mGhr); end
      tests++; if (bus.branch_cnt !== mB[31:0] || bus.mispred_cnt !== mM[31:0]) begin
        fails++; $display("FAIL rnd_counters i=%0d got=%0d/%0d want=%0d/%0d", i, bus.branch_cnt, bus.mispred_cnt, mB[31:0], mM[31:0]); end
      tests++; if (bus3.branch_cnt !== mB3[2:0] || bus3.mispred_cnt !== mM3[2:0]) begin
        fails++; $display("FAIL rnd_narrow_counters i=%0d got=%0d/%0d want=%0d/%0d", i, bus3.branch_cnt, bus3.mispred_cnt, mB3[2:0], mM3[2:0]); end
    end
    bus.stallE = 0; bus.flushM = 0; bus.cnt_clr = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_beq_mispredict();
    test_bltz_correct();
    test_back_to_back();
    test_ghr();
    test_saturate();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
